// File: rtl/ram_scan_reader_pkg.sv
// Shared types and default sizing for the RAM scan reader.
// Imported by the scan FSM and its dwell timer.
package ram_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } scan_state_t;

    localparam int SCAN_ADDR_WIDTH    = 5;
    localparam int SCAN_DATA_WIDTH    = 4;
    localparam int SCAN_READ_LATENCY  = 2;
    localparam int SCAN_DWELL_DEFAULT = 50_000_000;

endpackage

// File: rtl/ram_scan_reader_dwell_timer.sv
// Counts COUNT cycles while run is high; done marks the final count cycle.
// clear (or done) returns the count to zero on the next edge.
module dwell_timer #(
    parameter int COUNT = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic done
);

    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign done = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || done) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_scan_reader.sv
// Autonomous read master: walks every RAM address, waits out the read
// latency, captures the word and holds it for a dwell time before advancing.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int ADDR_WIDTH   = SCAN_ADDR_WIDTH,
    parameter int DATA_WIDTH   = SCAN_DATA_WIDTH,
    parameter int READ_LATENCY = SCAN_READ_LATENCY,
    parameter int DWELL_CYCLES = SCAN_DWELL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  restart,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] disp_addr,
    output logic [DATA_WIDTH-1:0] disp_data,
    output logic                  disp_valid,
    output logic                  wrap
);

    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

    scan_state_t state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [DATA_WIDTH-1:0] ddata_q, ddata_d;
    logic dvalid_q, dvalid_d;
    logic wrap_q, wrap_d;

    logic hold_run;
    logic dwell_done;

    // The timer only advances while the hold is actually in progress.
    assign hold_run = (state_q == S_HOLD) && enable && !restart;

    dwell_timer #(
        .COUNT (DWELL_CYCLES)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clear (!hold_run),
        .run   (hold_run),
        .done  (dwell_done)
    );

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        addr_d   = addr_q;
        daddr_d  = daddr_q;
        ddata_d  = ddata_q;
        dvalid_d = dvalid_q;
        wrap_d   = 1'b0;

        if (restart) begin
            addr_d   = '0;
            lat_d    = '0;
            dvalid_d = 1'b0;
            state_d  = enable ? S_WAIT : S_IDLE;
        end else begin
            unique case (1'b1)
                (state_q == S_IDLE): begin
                    lat_d = '0;
                    if (enable) begin
                        state_d = S_WAIT;
                    end
                end
                (state_q == S_WAIT): begin
                    if (!enable) begin
                        state_d = S_IDLE;
                        lat_d   = '0;
                    end else if (lat_q == LAT_LAST) begin
                        ddata_d  = ram_q;
                        daddr_d  = addr_q;
                        dvalid_d = 1'b1;
                        lat_d    = '0;
                        state_d  = S_HOLD;
                    end else begin
                        lat_d = lat_q + LW'(1);
                    end
                end
                (state_q == S_HOLD): begin
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else if (dwell_done) begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        wrap_d  = (addr_q == ADDR_TOP);
                        lat_d   = '0;
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lat_q    <= '0;
            addr_q   <= '0;
            daddr_q  <= '0;
            ddata_q  <= '0;
            dvalid_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            addr_q   <= addr_d;
            daddr_q  <= daddr_d;
            ddata_q  <= ddata_d;
            dvalid_q <= dvalid_d;
            wrap_q   <= wrap_d;
        end
    end

    assign ram_addr   = addr_q;
    assign ram_wren   = 1'b0;
    assign disp_addr  = daddr_q;
    assign disp_data  = ddata_q;
    assign disp_valid = dvalid_q;
    assign wrap       = wrap_q;

endmodule
